// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, mux selects, control word.
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  // {aluop1, aluop0}
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_SEXT    = 2'b10;
  localparam logic [1:0] ALUB_SEXT_SH = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore control-word decode of the FSM state; only the fetch strobes look at memready.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state_i,
  input  logic   memready_i,
  output ctrl_t  ctrl_o
);

  // Per-state datapath controls; unused encodings leave everything at 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memread  = 1'b1;
        ctrl_o.alusrcb  = ALUB_FOUR;
        ctrl_o.aluop    = ALUOP_ADD;
        ctrl_o.pcsource = PCSRC_ALU;
        ctrl_o.irwrite  = memready_i;
        ctrl_o.pcwrite  = memready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = ALUB_SEXT_SH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUB_SEXT;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUB_REG;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.alusrcb     = ALUB_REG;
        ctrl_o.aluop       = ALUOP_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsource    = PCSRC_ALUOUT;
      end
      S_JMP: begin
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.pcsource = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: state register, next-state logic, reset gating.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned OPW  = OP_W,
  parameter int unsigned ST_W = STATE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  op,
  input  logic            memready,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            memtoreg,
  output logic            regdst,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsource,
  output logic            aluop1,
  output logic            aluop0,
  output logic            illegal,
  output logic [ST_W-1:0] state_dbg
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] opc;
  logic            illegal_c;
  ctrl_t           ctrl, ctrl_g;

  assign opc = OP_W'(op);

  // State register; reset returns to FETCH and aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection; an unknown opcode in DECODE flags illegal and refetches.
  always_comb begin
    state_d   = S_FETCH;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  state_d = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opc)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if      (opc == OP_LW) state_d = S_MEMRD;
        else if (opc == OP_SW) state_d = S_MEMWR;
        else                   state_d = S_FETCH;
      end
      S_MEMRD:  state_d = memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = memready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i    (state_q),
    .memready_i (memready),
    .ctrl_o     (ctrl)
  );

  // Every output reads 0 while reset is held, so no write enable fires in the reset cycle.
  assign ctrl_g = reset ? '0 : ctrl;

  assign pcwrite     = ctrl_g.pcwrite;
  assign pcwritecond = ctrl_g.pcwritecond;
  assign iord        = ctrl_g.iord;
  assign memread     = ctrl_g.memread;
  assign memwrite    = ctrl_g.memwrite;
  assign irwrite     = ctrl_g.irwrite;
  assign memtoreg    = ctrl_g.memtoreg;
  assign regdst      = ctrl_g.regdst;
  assign regwrite    = ctrl_g.regwrite;
  assign alusrca     = ctrl_g.alusrca;
  assign alusrcb     = ctrl_g.alusrcb;
  assign pcsource    = ctrl_g.pcsource;
  assign aluop1      = ctrl_g.aluop[1];
  assign aluop0      = ctrl_g.aluop[0];
  assign illegal     = illegal_c & ~reset;
  assign state_dbg   = reset ? '0 : ST_W'(state_q);

endmodule
